// File: rtl/sv39_tlb.sv
// sv39_tlb: fully-associative Sv39 translation cache between the core's
// address generation and the page-table walker. Hits translate
// combinationally; misses stall the core, request a walk and refill one
// entry. Handles 4K/2M/1G leaves, sfence.vma and flush on satp change.
module sv39_tlb #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned PTR_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [63:0] vaddr,
  input  logic [1:0]  priv,
  input  logic [63:0] satp,
  input  logic        flush,
  output logic        resp_valid,
  output logic [63:0] paddr,
  output logic        resp_fault,
  output logic        stall,
  output logic        walk_req,
  output logic [63:0] walk_vaddr,
  input  logic        walk_done,
  input  logic [43:0] walk_ppn,
  input  logic [1:0]  walk_level,
  input  logic        walk_fault
);

  typedef enum logic [1:0] {IDLE, WALK, REFILL, FAULT} state_t;

  state_t             r_state;
  state_t             w_next;

  logic [ENTRIES-1:0] r_valid;
  logic [26:0]        r_vpn [ENTRIES];
  logic [43:0]        r_ppn [ENTRIES];
  logic [1:0]         r_lvl [ENTRIES];
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_drop;
  logic [63:0]        r_last_satp;
  logic [63:0]        r_walk_vaddr;
  logic [43:0]        r_fill_ppn;
  logic [1:0]         r_fill_lvl;

  logic [26:0]        w_vpn;
  logic               w_bypass;
  logic               w_flush;
  logic [ENTRIES-1:0] w_match;
  logic               w_hit;
  logic [PTR_W-1:0]   w_hit_idx;
  logic [43:0]        w_hit_ppn;
  logic [63:0]        w_hit_paddr;
  logic               w_has_free;
  logic [PTR_W-1:0]   w_free_idx;
  logic [PTR_W-1:0]   w_victim;
  logic               w_miss;
  logic               w_fill_en;

  assign w_vpn      = vaddr[38:12];
  assign w_bypass   = (satp[63:60] != 4'h8) || (priv == 2'b11);
  assign w_flush    = flush || (satp != r_last_satp);
  assign walk_vaddr = r_walk_vaddr;

  // Per-entry tag compare; superpage entries ignore the low VPN fields
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      case (r_lvl[i])
        2'd2:    w_match[i] = r_valid[i] && (r_vpn[i][26:18] == w_vpn[26:18]);
        2'd1:    w_match[i] = r_valid[i] && (r_vpn[i][26:9] == w_vpn[26:9]);
        default: w_match[i] = r_valid[i] && (r_vpn[i] == w_vpn);
      endcase
    end
  end

  // Priority select: lowest matching index wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!w_hit && w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  // Physical address composition for the selected entry's page size
  always_comb begin
    w_hit_ppn = r_ppn[w_hit_idx];
    case (r_lvl[w_hit_idx])
      2'd2:    w_hit_paddr = {8'b0, w_hit_ppn[43:18], vaddr[29:0]};
      2'd1:    w_hit_paddr = {8'b0, w_hit_ppn[43:9], vaddr[20:0]};
      default: w_hit_paddr = {8'b0, w_hit_ppn, vaddr[11:0]};
    endcase
  end

  // Victim choice: lowest free slot, else the round-robin pointer
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!w_has_free && !r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = PTR_W'(i);
      end
    end
    w_victim = w_has_free ? w_free_idx : r_rr_ptr;
  end

  // Next-state and response outputs; bypass overrides the core-facing side
  always_comb begin
    w_next     = r_state;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    paddr      = '0;
    stall      = 1'b0;
    walk_req   = 1'b0;
    w_miss     = 1'b0;
    w_fill_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && !w_bypass) begin
          if (w_hit) begin
            resp_valid = 1'b1;
            paddr      = w_hit_paddr;
          end else begin
            stall  = 1'b1;
            w_miss = 1'b1;
            w_next = WALK;
          end
        end
      end
      WALK: begin
        walk_req = 1'b1;
        stall    = 1'b1;
        // a flush seen during the walk (or coincident with its result) makes the result stale
        if (walk_done) begin
          if (r_drop || w_flush) w_next = IDLE;
          else if (walk_fault)   w_next = FAULT;
          else                   w_next = REFILL;
        end
      end
      REFILL: begin
        stall     = 1'b1;
        w_fill_en = !w_flush;
        w_next    = IDLE;
      end
      FAULT: begin
        resp_valid = 1'b1;
        resp_fault = 1'b1;
        w_next     = IDLE;
      end
    endcase
    if (w_bypass) begin
      resp_valid = req_valid;
      resp_fault = 1'b0;
      paddr      = vaddr;
      stall      = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Entry array: flush clears valids and beats a coincident refill
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
    end else if (w_fill_en) begin
      r_valid[w_victim] <= 1'b1;
      r_vpn[w_victim]   <= r_walk_vaddr[38:12];
      r_ppn[w_victim]   <= r_fill_ppn;
      r_lvl[w_victim]   <= r_fill_lvl;
    end
  end

  // Round-robin pointer advances only when a valid entry is evicted
  always_ff @(posedge clk) begin
    if (!rst)                          r_rr_ptr <= '0;
    else if (w_fill_en && !w_has_free) r_rr_ptr <= r_rr_ptr + 1'b1;
  end

  // Drop flag marks an in-flight walk as stale after a flush
  always_ff @(posedge clk) begin
    if (!rst)                r_drop <= 1'b0;
    else if (r_state != WALK) r_drop <= 1'b0;
    else if (walk_done)      r_drop <= 1'b0;
    else if (w_flush)        r_drop <= 1'b1;
  end

  // Miss address, walker result capture and satp history
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_walk_vaddr <= '0;
      r_fill_ppn   <= '0;
      r_fill_lvl   <= '0;
      r_last_satp  <= '0;
    end else begin
      r_last_satp <= satp;
      if (w_miss) r_walk_vaddr <= vaddr;
      if (r_state == WALK && walk_done) begin
        r_fill_ppn <= walk_ppn;
        r_fill_lvl <= walk_level;
      end
    end
  end

endmodule

// File: tb/tb_sv39_tlb.sv
// tb_sv39_tlb: scoreboard bench for sv39_tlb with a walker responder and a
// page-granular reference model of the translation cache.
module tb_sv39_tlb;

  localparam logic [63:0] SATP_A = 64'h8000_0000_0008_0000;
  localparam logic [63:0] SATP_B = 64'h8000_0000_0009_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] vaddr;
  logic [1:0]  priv;
  logic [63:0] satp;
  logic        flush;
  logic        resp_valid;
  logic [63:0] paddr;
  logic        resp_fault;
  logic        stall;
  logic        walk_req;
  logic [63:0] walk_vaddr;
  logic        walk_done;
  logic [43:0] walk_ppn;
  logic [1:0]  walk_level;
  logic        walk_fault;

  always #5 clk = ~clk;

  sv39_tlb #(.ENTRIES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .vaddr(vaddr), .priv(priv),
    .satp(satp), .flush(flush), .resp_valid(resp_valid), .paddr(paddr),
    .resp_fault(resp_fault), .stall(stall), .walk_req(walk_req),
    .walk_vaddr(walk_vaddr), .walk_done(walk_done), .walk_ppn(walk_ppn),
    .walk_level(walk_level), .walk_fault(walk_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  typedef struct {
    logic [63:0] paddr;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  // Reference model: a list of cached pages
  logic        m_valid [8];
  logic [26:0] m_vpn   [8];
  logic [43:0] m_ppn   [8];
  int          m_lvl   [8];
  int          m_rr;
  int          walks_exp  = 0;
  int          walks_seen = 0;

  // Walker stimulus for the current request
  logic [63:0] wk_va;
  logic [43:0] wk_ppn;
  int          wk_lvl;
  logic        wk_flt;
  int          wk_d;

  function automatic logic [63:0] compose(input logic [43:0] ppn, input int lvl, input logic [63:0] va);
    int          sh;
    logic [63:0] mask;
    sh   = 12 + 9 * lvl;
    mask = (64'd1 << sh) - 64'd1;
    return ((64'(ppn) >> (9 * lvl)) << sh) | (va & mask);
  endfunction

  function automatic bit m_lookup(input logic [63:0] va, output logic [63:0] pa);
    logic [26:0] vpn;
    vpn = va[38:12];
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && ((m_vpn[i] >> (9 * m_lvl[i])) == (vpn >> (9 * m_lvl[i])))) begin
        pa = compose(m_ppn[i], m_lvl[i], va);
        return 1'b1;
      end
    end
    pa = '0;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [63:0] va, input logic [43:0] ppn, input int lvl);
    int idx;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (idx < 0 && !m_valid[i]) idx = i;
    end
    if (idx < 0) begin
      idx  = m_rr;
      m_rr = (m_rr + 1) % 8;
    end
    m_valid[idx] = 1'b1;
    m_vpn[idx]   = va[38:12];
    m_ppn[idx]   = ppn;
    m_lvl[idx]   = lvl;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  // Issue one request, hold it until the DUT responds
  task automatic do_req(input logic [63:0] va, input logic [43:0] ppn, input int lvl,
                        input logic flt, input int d, input logic fmid);
    exp_t        e;
    logic [63:0] pa;
    int          waitc;
    if ((satp[63:60] != 4'h8) || (priv == 2'b11)) begin
      e.paddr = va; e.fault = 1'b0; e.lat = 0;
    end else if (m_lookup(va, pa)) begin
      e.paddr = pa; e.fault = 1'b0; e.lat = 0;
    end else begin
      walks_exp++;
      if (fmid) begin
        m_flush();
        walks_exp++;
      end
      if (flt) begin
        e.paddr = '0; e.fault = 1'b1; e.lat = fmid ? 2 * d + 4 : d + 2;
      end else begin
        m_fill(va, ppn, lvl);
        e.paddr = compose(ppn, lvl, va); e.fault = 1'b0; e.lat = fmid ? 2 * d + 5 : d + 3;
      end
    end
    wk_va = va; wk_ppn = ppn; wk_lvl = lvl; wk_flt = flt; wk_d = d;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1;
    vaddr     = va;
    waitc     = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) break;
      waitc++;
      if (waitc > 40) begin
        check("resp_timeout", {63'b0, resp_valid}, 64'd1);
        break;
      end
      @(posedge clk); #1;
      flush = fmid && (waitc == 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Request that is withdrawn while stalled; the walk still refills
  task automatic drop_req(input logic [63:0] va, input logic [43:0] ppn, input int lvl, input int d);
    walks_exp++;
    m_fill(va, ppn, lvl);
    wk_va = va; wk_ppn = ppn; wk_lvl = lvl; wk_flt = 1'b0; wk_d = d;
    @(posedge clk); #1;
    req_valid = 1'b1;
    vaddr     = va;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (d + 4) @(posedge clk);
    #1;
  endtask

  task automatic sfence();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    m_flush();
  endtask

  task automatic set_satp(input logic [63:0] v);
    @(posedge clk); #1;
    if (v != satp) m_flush();
    satp = v;
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0;
      end else if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", {63'b0, resp_valid}, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("paddr", paddr, e.paddr);
          check("resp_fault", {63'b0, resp_fault}, {63'b0, e.fault});
          check("stall_on_resp", {63'b0, stall}, 64'd0);
          check("latency", 64'(cnt), 64'(e.lat));
        end
        cnt = 0;
      end else if (req_valid) begin
        check("stall_held", {63'b0, stall}, 64'd1);
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Walker responder: answers each walk after wk_d extra cycles
  initial begin
    walk_done  = 1'b0;
    walk_fault = 1'b0;
    walk_ppn   = '0;
    walk_level = '0;
    forever begin
      @(negedge clk);
      if (walk_req) begin
        walks_seen++;
        check("walk_vaddr", walk_vaddr, wk_va);
        repeat (wk_d) @(negedge clk);
        walk_ppn   = wk_ppn;
        walk_level = wk_lvl[1:0];
        walk_fault = wk_flt;
        walk_done  = 1'b1;
        @(negedge clk);
        walk_done  = 1'b0;
        walk_fault = 1'b0;
        check("walk_req_release", {63'b0, walk_req}, 64'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] pool_va  [12];
  logic [63:0] pool_msk [12];
  logic [43:0] pool_ppn [12];
  int          pool_lvl [12];

  initial begin
    rst = 1'b0; req_valid = 1'b0; vaddr = '0; priv = 2'b00; satp = '0; flush = 1'b0;
    m_flush();
    m_rr = 0;
    wk_va = '0; wk_ppn = '0; wk_lvl = 0; wk_flt = 1'b0; wk_d = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("reset_walk_req", {63'b0, walk_req}, 64'd0);
    check("reset_stall", {63'b0, stall}, 64'd0);
    check("reset_walk_vaddr", walk_vaddr, 64'd0);

    // Bypass: machine mode, then bare satp
    priv = 2'b11;
    set_satp(SATP_A);
    do_req(64'h1234, 44'h0, 0, 1'b0, 0, 1'b0);
    priv = 2'b00;
    set_satp(64'h0);
    do_req(64'hDEAD_BEEF, 44'h0, 0, 1'b0, 0, 1'b0);
    set_satp(SATP_A);
    priv = 2'b01;

    // 4K miss with a three-cycle walk, then a zero-latency hit
    do_req(64'h4000_1ABC, 44'h80200, 0, 1'b0, 2, 1'b0);
    do_req(64'h4000_1ABC, 44'h80200, 0, 1'b0, 2, 1'b0);
    // 2M leaf covers a neighbouring address
    do_req(64'h0060_0000, 44'h80400, 1, 1'b0, 1, 1'b0);
    do_req(64'h0061_2345, 44'h80400, 1, 1'b0, 1, 1'b0);

    // Fill all entries, evict via round robin, re-access the first page
    sfence();
    for (int i = 0; i < 9; i++)
      do_req(64'h10_0000_0000 + 64'(i) * 64'h1000, 44'h90000 + 44'(i), 0, 1'b0, i % 4, 1'b0);
    do_req(64'h10_0000_0000, 44'h90000, 0, 1'b0, 1, 1'b0);
    do_req(64'h10_0000_8000, 44'h90008, 0, 1'b0, 1, 1'b0);

    // Flush during walk drops the result and forces a re-walk
    do_req(64'h20_0000_5678, 44'hA0000, 0, 1'b0, 2, 1'b1);
    do_req(64'h20_0000_5678, 44'hA0000, 0, 1'b0, 2, 1'b0);
    do_req(64'h20_0000_9000, 44'hA0001, 0, 1'b0, 0, 1'b1);

    // satp write invalidates prior translations
    set_satp(SATP_B);
    do_req(64'h4000_1ABC, 44'h80300, 0, 1'b0, 1, 1'b0);

    // Faulting walk, repeated: no entry is installed
    do_req(64'h30_0000_0000, 44'h0, 0, 1'b1, 1, 1'b0);
    do_req(64'h30_0000_0000, 44'h0, 0, 1'b1, 0, 1'b0);

    // Withdrawn request still refills
    drop_req(64'h38_0000_3000, 44'hB1234, 0, 2);
    do_req(64'h38_0000_3FFF, 44'hB1234, 0, 1'b0, 0, 1'b0);

    // Randomised traffic over a small page pool
    sfence();
    for (int k = 0; k < 12; k++) begin
      pool_lvl[k] = k % 3;
      pool_ppn[k] = {12'($urandom), 32'($urandom)};
      pool_va[k]  = 64'(k + 1) << 30;
      case (pool_lvl[k])
        0:       begin pool_va[k] |= 64'($urandom) & 64'h3FFF_F000; pool_msk[k] = 64'hFFF; end
        1:       begin pool_va[k] |= 64'($urandom) & 64'h3FE0_0000; pool_msk[k] = 64'h1F_FFFF; end
        default: pool_msk[k] = 64'h3FFF_FFFF;
      endcase
    end
    for (int n = 0; n < 200; n++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if (r < 3) sfence();
      else if (r < 5) set_satp(SATP_A);
      else if (r < 7) set_satp(SATP_B);
      else if (r == 7) set_satp(64'h0);
      priv = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      k = $urandom_range(0, 11);
      do_req(pool_va[k] | (64'($urandom) & pool_msk[k]), pool_ppn[k], pool_lvl[k],
             k == 11, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
    end

    // Reset in the middle of a walk abandons it; late walk_done is ignored
    priv = 2'b00;
    set_satp(SATP_A);
    wk_va = 64'h40_0000_7000; wk_ppn = 44'hC0000; wk_lvl = 0; wk_flt = 1'b0; wk_d = 3;
    walks_exp++;
    @(posedge clk); #1;
    req_valid = 1'b1;
    vaddr     = 64'h40_0000_7000;
    @(negedge clk);
    check("midwalk_stall", {63'b0, stall}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midwalk_walk_req", {63'b0, walk_req}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_reset_walk_req", {63'b0, walk_req}, 64'd0);
    check("post_reset_stall", {63'b0, stall}, 64'd0);
    check("post_reset_walk_vaddr", walk_vaddr, 64'd0);
    m_flush();
    m_rr = 0;
    repeat (6) @(posedge clk);
    #1;
    check("late_done_ignored", {63'b0, walk_req}, 64'd0);
    do_req(64'h40_0000_7000, 44'hC0000, 0, 1'b0, 1, 1'b0);
    do_req(64'h40_0000_7123, 44'hC0000, 0, 1'b0, 1, 1'b0);

    repeat (5) @(posedge clk);
    check("walk_count", 64'(walks_seen), 64'(walks_exp));
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
